// File: rtl/pru1_cpu_oci_pkg.sv
// Shared definitions for the OCI debug-RAM arbiter.
// Contents: arbiter FSM state enum, requester enum and the bit positions of
// the fields carried in the 38-bit JTAG jdo payload.
package pru1_cpu_oci_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_JTAG = 1'b1
  } grant_e;

  // jdo field layout
  localparam int JDO_ADDR_LSB  = 17;  // word address occupies jdo[ADDR_W+16:17]
  localparam int JDO_RDEN_BIT  = 34;  // ocimem_a: also queue a read
  localparam int JDO_WDATA_MSB = 34;  // ocimem_b: write data jdo[34:3]
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/pru1_cpu_oci_jtag_cmd.sv
// JTAG ocimem command intake.
// Decodes take_* pulses and jdo, maintains the post-incrementing JTAG address
// pointer and a single-entry holding register {rd/wr, addr, data} that the
// arbiter drains, plus a sticky overflow flag for dropped commands.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   i_jdo               38-bit JTAG payload, valid with a take_* pulse
//   i_take_a/na/b       ocimem_a, no-action ocimem_a, ocimem_b command pulses
//   i_pop               arbiter granted the pending entry this cycle
//   o_pending           holding register occupied
//   o_is_wr/o_addr/o_wdata  pending command contents
//   o_capture           a command was accepted into the holding register
//   o_overflow          sticky: a command arrived while the register was full
module pru1_cpu_oci_jtag_cmd
  import pru1_cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       i_jdo,
  input  logic              i_take_a,
  input  logic              i_take_na,
  input  logic              i_take_b,
  input  logic              i_pop,
  output logic              o_pending,
  output logic              o_is_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_capture,
  output logic              o_overflow
);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_pending;
  logic              r_is_wr;
  logic              r_overflow;

  logic [ADDR_W-1:0] w_jdo_addr;
  logic [ADDR_W-1:0] w_base;
  logic              w_any;
  logic              w_queue;
  logic              w_free;
  logic              w_unused;

  assign w_jdo_addr = i_jdo[JDO_ADDR_LSB +: ADDR_W];
  assign w_any      = i_take_a | i_take_na | i_take_b;
  // ocimem_a without the read bit only moves the pointer
  assign w_queue    = (i_take_a & i_jdo[JDO_RDEN_BIT]) | i_take_na | i_take_b;
  // The entry frees at grant, so a pulse in the grant cycle is still accepted
  assign w_free     = ~r_pending | i_pop;
  assign w_base     = i_take_a ? w_jdo_addr : r_ptr;
  assign w_unused   = ^{i_jdo[37:35], i_jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pending  <= 1'b0;
      r_is_wr    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_pop) begin
        r_pending <= 1'b0;
      end
      if (w_any) begin
        if (w_free) begin
          if (w_queue) begin
            r_pending <= 1'b1;
            r_is_wr   <= i_take_b;
            r_addr    <= w_base;
            r_wdata   <= i_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            r_ptr     <= w_base + ADDR_W'(1);
          end else begin
            r_ptr <= w_jdo_addr;
          end
        end else begin
          // Dropped command: pointer is left exactly where it was
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_is_wr    = r_is_wr;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_capture  = w_any & w_free & w_queue;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pru1_cpu_oci_ram_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug monitor RAM between
// the JTAG ocimem command path and the CPU Avalon-MM debug slave.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   jdo, take_*                JTAG command payload and pulses
//   cpu_*                      Avalon-MM slave (read/write, waitrequest, readdata)
//   ram_*                      OCI RAM macro interface (read data one cycle after ram_re)
//   MonDReg, monitor_ready     last JTAG read result and JTAG completion flag
//   jtag_overflow              sticky flag: a JTAG command was dropped
module pru1_cpu_oci_ram_arbiter
  import pru1_cpu_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overflow
);

  generate
    if (DATA_W != 32) begin : g_data_w_check
      $fatal(1, "pru1_cpu_oci_ram_arbiter: DATA_W must be 32");
    end
    if (ADDR_W < 1 || ADDR_W > 14) begin : g_addr_w_check
      $fatal(1, "pru1_cpu_oci_ram_arbiter: ADDR_W must be in 1..14");
    end
  endgenerate

  arb_state_e        r_state;
  grant_e            r_last_grant;
  grant_e            r_owner;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic [3:0]        r_ram_be;
  logic              r_ram_we;
  logic              r_ram_re;
  logic              r_waitrequest;
  logic              r_cpu_rd_done;
  logic [31:0]       r_mondreg;
  logic              r_monitor_ready;

  logic              w_jtag_pending;
  logic              w_jtag_is_wr;
  logic [ADDR_W-1:0] w_jtag_addr;
  logic [31:0]       w_jtag_wdata;
  logic              w_jtag_capture;
  logic              w_jtag_overflow;
  logic              w_cpu_req;
  logic              w_grant_jtag;
  logic              w_grant_cpu;

  pru1_cpu_oci_jtag_cmd #(
    .ADDR_W (ADDR_W)
  ) u_jtag_cmd (
    .clk        (clk),
    .reset      (reset),
    .i_jdo      (jdo),
    .i_take_a   (take_action_ocimem_a),
    .i_take_na  (take_no_action_ocimem_a),
    .i_take_b   (take_action_ocimem_b),
    .i_pop      (w_grant_jtag),
    .o_pending  (w_jtag_pending),
    .o_is_wr    (w_jtag_is_wr),
    .o_addr     (w_jtag_addr),
    .o_wdata    (w_jtag_wdata),
    .o_capture  (w_jtag_capture),
    .o_overflow (w_jtag_overflow)
  );

  assign w_cpu_req = cpu_read | cpu_write;

  // On a tie the requester that did not win last time goes first
  assign w_grant_jtag = (r_state == ARB) && w_jtag_pending &&
                        (!w_cpu_req || (r_last_grant == GRANT_CPU));
  assign w_grant_cpu  = (r_state == ARB) && w_cpu_req && !w_grant_jtag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ARB;
      r_last_grant    <= GRANT_CPU;
      r_owner         <= GRANT_CPU;
      r_ram_addr      <= '0;
      r_ram_wdata     <= '0;
      r_ram_be        <= '0;
      r_ram_we        <= 1'b0;
      r_ram_re        <= 1'b0;
      r_waitrequest   <= 1'b1;
      r_cpu_rd_done   <= 1'b0;
      r_mondreg       <= '0;
      r_monitor_ready <= 1'b0;
    end else begin
      r_ram_we      <= 1'b0;
      r_ram_re      <= 1'b0;
      r_waitrequest <= 1'b1;
      r_cpu_rd_done <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_grant_jtag) begin
            r_owner      <= GRANT_JTAG;
            r_last_grant <= GRANT_JTAG;
            r_ram_addr   <= w_jtag_addr;
            r_ram_wdata  <= w_jtag_wdata;
            r_ram_be     <= 4'hF;
            r_ram_we     <= w_jtag_is_wr;
            r_ram_re     <= !w_jtag_is_wr;
            r_state      <= ISSUE;
          end else if (w_grant_cpu) begin
            r_owner      <= GRANT_CPU;
            r_last_grant <= GRANT_CPU;
            r_ram_addr   <= cpu_address;
            r_ram_wdata  <= cpu_writedata;
            r_ram_be     <= cpu_byteenable;
            r_ram_we     <= cpu_write;
            r_ram_re     <= !cpu_write;
            // A CPU write completes in the ISSUE cycle itself
            r_waitrequest <= !cpu_write;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          // r_ram_we is high in ISSUE exactly when the granted access is a write
          if (r_ram_we) begin
            r_state <= ARB;
            if (r_owner == GRANT_JTAG) begin
              r_monitor_ready <= 1'b1;
            end
          end else begin
            r_state <= DONE;
            if (r_owner == GRANT_CPU) begin
              r_waitrequest <= 1'b0;
              r_cpu_rd_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (r_owner == GRANT_JTAG) begin
            r_mondreg       <= ram_rdata;
            r_monitor_ready <= 1'b1;
          end
          r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
      // A newly accepted JTAG command means the host is waiting again
      if (w_jtag_capture) begin
        r_monitor_ready <= 1'b0;
      end
    end
  end

  assign cpu_waitrequest = r_waitrequest;
  // RAM read data is only valid in the DONE cycle, so it is passed straight
  // through while the CPU read completes and held at zero otherwise.
  assign cpu_readdata    = r_cpu_rd_done ? ram_rdata : '0;
  assign ram_addr        = r_ram_addr;
  assign ram_wdata       = r_ram_wdata;
  assign ram_byteenable  = r_ram_be;
  assign ram_we          = r_ram_we;
  assign ram_re          = r_ram_re;
  assign MonDReg         = r_mondreg;
  assign monitor_ready   = r_monitor_ready;
  assign jtag_overflow   = w_jtag_overflow;

endmodule

// File: tb/tb_pru1_cpu_oci_ram_arbiter.sv
module tb_pru1_cpu_oci_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteenable;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overflow;

  pru1_cpu_oci_ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_byteenable          (ram_byteenable),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overflow           (jtag_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // RAM macro behaviour, and the bench's own view of what memory should hold
  bit [31:0] bram [256];
  bit [31:0] mem  [256];
  logic [7:0] ptr;   // expected JTAG pointer
  bit         mrdy;  // expected monitor_ready after completed ops
  bit         ovf;   // expected jtag_overflow

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteenable[b]) bram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_rdata <= bram[ram_addr];
  end

  typedef struct packed {
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } acc_t;
  acc_t acc_q[$];

  always @(negedge clk) begin
    if (ram_we || ram_re) acc_q.push_back('{ram_we, ram_addr, ram_wdata, ram_byteenable});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_jdo(input logic [7:0] a, input bit rd, input bit is_b,
                                         input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    if (is_b) begin
      j[34:3] = d;
    end else begin
      j[24:17] = a;
      j[34]    = rd;
    end
    return j;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Called at posedge+1; holds the Avalon request until waitrequest drops.
  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int exp_lat);
    int n;
    bit seen;
    logic [31:0] exp_rd;
    n = 0;
    seen = 0;
    exp_rd = mem[a];
    cpu_address = a; cpu_read = !wr; cpu_write = wr; cpu_writedata = d; cpu_byteenable = be;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (!cpu_waitrequest) begin
        seen = 1;
        if (wr) begin
          check_val("cpu_wr_we", ram_we, 1'b1);
          check_val("cpu_wr_addr", ram_addr, a);
          check_val("cpu_wr_data", ram_wdata, d);
          check_val("cpu_wr_be", ram_byteenable, be);
        end else begin
          check_val("cpu_rd_data", cpu_readdata, exp_rd);
        end
      end
    end
    check_val("cpu_done", seen, 1'b1);
    if (exp_lat > 0) check_val("cpu_latency", n, exp_lat);
    tick();
    cpu_read = 0; cpu_write = 0;
    if (wr) mem[a] = merge_be(mem[a], d, be);
    $display("cpu %s a=%02h d=%08h be=%h wait=%0d", wr ? "wr" : "rd", a, wr ? d : exp_rd, be, n);
  endtask

  // kind 0 = ocimem_a, 1 = no-action ocimem_a, 2 = ocimem_b; called at posedge+1
  task automatic jtag_pulse(input int kind, input logic [37:0] j);
    jdo = j;
    ta_a = (kind == 0); tna_a = (kind == 1); ta_b = (kind == 2);
    tick();
    ta_a = 0; tna_a = 0; ta_b = 0; jdo = '0;
  endtask

  task automatic jtag_wait(input bit is_rd, input logic [31:0] exp_mon, input int exp_lat);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (n < 40 && !done) begin
      @(negedge clk);
      n++;
      if (monitor_ready) done = 1;
    end
    check_val("jtag_ready", done, 1'b1);
    if (exp_lat > 0) check_val("jtag_latency", n, exp_lat);
    if (is_rd) check_val("mondreg", MonDReg, exp_mon);
    check_val("jtag_overflow", jtag_overflow, ovf);
    mrdy = 1;
    $display("jtag %s mon=%08h ready_after=%0d", is_rd ? "rd" : "wr", MonDReg, n);
    tick();
  endtask

  task automatic check_acc(input string tag, input int exp_n, input bit we, input logic [7:0] a,
                           input logic [31:0] d, input bit chk_d);
    check_val({tag, "_count"}, acc_q.size(), exp_n);
    if (acc_q.size() > 0 && exp_n > 0) begin
      check_val({tag, "_we"}, acc_q[0].we, we);
      check_val({tag, "_addr"}, acc_q[0].a, a);
      if (chk_d) begin
        check_val({tag, "_wdata"}, acc_q[0].d, d);
        check_val({tag, "_be"}, acc_q[0].be, 4'hF);
      end
    end
  endtask

  int kind;
  logic [7:0] a, p0;
  logic [31:0] d, e;
  logic [3:0] be;

  initial begin
    reset = 1; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    ptr = 8'h00; mrdy = 0; ovf = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_val("rst_waitrequest", cpu_waitrequest, 1'b1);
    check_val("rst_readdata", cpu_readdata, 32'h0);
    check_val("rst_ram_we", ram_we, 1'b0);
    check_val("rst_ram_re", ram_re, 1'b0);
    check_val("rst_ram_addr", ram_addr, 8'h00);
    check_val("rst_ram_wdata", ram_wdata, 32'h0);
    check_val("rst_ram_be", ram_byteenable, 4'h0);
    check_val("rst_mondreg", MonDReg, 32'h0);
    check_val("rst_ready", monitor_ready, 1'b0);
    check_val("rst_overflow", jtag_overflow, 1'b0);
    tick();

    // JTAG read through ocimem_a with pointer load
    cpu_op(1, 8'h10, 32'hDEADBEEF, 4'hF, 2);
    acc_q.delete();
    jtag_pulse(0, mk_jdo(8'h10, 1, 0, 32'h0));
    jtag_wait(1, 32'hDEADBEEF, 4);
    check_acc("a_rd", 1, 0, 8'h10, 32'h0, 0);
    ptr = 8'h11;
    acc_q.delete();
    e = mem[ptr];
    jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
    jtag_wait(1, e, 4);
    check_acc("na_rd", 1, 0, 8'h11, 32'h0, 0);
    ptr = ptr + 8'd1;

    // Pointer wrap with ocimem_b writes
    jtag_pulse(0, mk_jdo(8'hFE, 0, 0, 32'h0));
    tick();
    ptr = 8'hFE;
    acc_q.delete();
    for (int k = 1; k <= 3; k++) begin
      jtag_pulse(2, mk_jdo(8'h00, 0, 1, 32'(k)));
      jtag_wait(0, 32'h0, 3);
      mem[ptr] = 32'(k);
      ptr = ptr + 8'd1;
    end
    check_val("wrap_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check_val("wrap_addr0", acc_q[0].a, 8'hFE);
      check_val("wrap_addr1", acc_q[1].a, 8'hFF);
      check_val("wrap_addr2", acc_q[2].a, 8'h00);
      check_val("wrap_be", acc_q[2].be, 4'hF);
      check_val("wrap_we", acc_q[1].we, 1'b1);
    end
    cpu_op(0, 8'hFF, 32'h0, 4'h0, 3);

    // Partial byte-enable CPU write
    cpu_op(1, 8'h05, 32'hA5A5A5A5, 4'b0011, 2);
    cpu_op(0, 8'h05, 32'h0, 4'h0, 3);

    // First tie: JTAG wins (last grant was the CPU write/read)
    acc_q.delete();
    e = mem[8'h20];
    fork
      begin
        jtag_pulse(0, mk_jdo(8'h20, 1, 0, 32'h0));
        jtag_wait(1, e, 4);
      end
      begin
        tick();
        cpu_op(0, 8'h30, 32'h0, 4'h0, 6);
      end
    join
    ptr = 8'h21;
    check_val("tie1_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check_val("tie1_first", acc_q[0].a, 8'h20);
      check_val("tie1_second", acc_q[1].a, 8'h30);
    end

    // Lone JTAG access so the next tie goes to the CPU
    e = mem[ptr];
    jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
    jtag_wait(1, e, 4);
    ptr = ptr + 8'd1;
    acc_q.delete();
    e = mem[8'h40];
    fork
      begin
        jtag_pulse(0, mk_jdo(8'h40, 1, 0, 32'h0));
        jtag_wait(1, e, 7);
      end
      begin
        tick();
        cpu_op(0, 8'h31, 32'h0, 4'h0, 3);
      end
    join
    ptr = 8'h41;
    check_val("tie2_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check_val("tie2_first", acc_q[0].a, 8'h31);
      check_val("tie2_second", acc_q[1].a, 8'h40);
    end

    // Two back-to-back JTAG pulses while a CPU read owns the RAM
    acc_q.delete();
    p0 = ptr;
    e = mem[p0];
    ovf = 1;
    fork
      cpu_op(0, 8'h07, 32'h0, 4'h0, 3);
      begin
        tick();
        jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
        jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
        jtag_wait(1, e, 4);
      end
    join
    ptr = p0 + 8'd1;
    check_val("ovf_count", acc_q.size(), 2);
    if (acc_q.size() == 2) check_val("ovf_jtag_addr", acc_q[1].a, p0);
    acc_q.delete();
    e = mem[ptr];
    jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
    jtag_wait(1, e, 4);
    check_acc("ovf_next", 1, 0, p0 + 8'd1, 32'h0, 0);
    ptr = ptr + 8'd1;

    // Randomised sequential traffic against the memory/pointer model
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 5));
      a = 8'($urandom_range(0, 15));
      d = $urandom();
      be = 4'($urandom());
      acc_q.delete();
      case (kind)
        0: cpu_op(1, a, d, be, 2);
        1: begin
          cpu_op(0, a, 32'h0, 4'h0, 3);
          check_acc("rnd_cpu_rd", 1, 0, a, 32'h0, 0);
        end
        2: begin
          e = mem[a];
          jtag_pulse(0, mk_jdo(a, 1, 0, 32'h0));
          jtag_wait(1, e, 4);
          check_acc("rnd_a_rd", 1, 0, a, 32'h0, 0);
          ptr = a + 8'd1;
        end
        3: begin
          jtag_pulse(0, mk_jdo(a, 0, 0, 32'h0));
          repeat (3) tick();
          check_acc("rnd_a_load", 0, 0, a, 32'h0, 0);
          check_val("rnd_a_load_ready", monitor_ready, mrdy);
          ptr = a;
          $display("jtag load ptr=%02h", a);
        end
        4: begin
          e = mem[ptr];
          jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
          jtag_wait(1, e, 4);
          check_acc("rnd_na_rd", 1, 0, ptr, 32'h0, 0);
          ptr = ptr + 8'd1;
        end
        default: begin
          jtag_pulse(2, mk_jdo(8'h00, 0, 1, d));
          jtag_wait(0, 32'h0, 3);
          check_acc("rnd_b_wr", 1, 1, ptr, d, 1);
          mem[ptr] = d;
          ptr = ptr + 8'd1;
        end
      endcase
    end

    // Reset during the ISSUE cycle of a CPU write
    cpu_address = 8'h33; cpu_writedata = 32'h12345678; cpu_byteenable = 4'hF; cpu_write = 1;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_we_before_reset", ram_we, 1'b1);
    reset = 1;
    tick();
    reset = 0; cpu_write = 0;
    mem[8'h33] = 32'h12345678;
    ptr = 8'h00; ovf = 0; mrdy = 0;
    @(negedge clk);
    check_val("mid_rst_we", ram_we, 1'b0);
    check_val("mid_rst_re", ram_re, 1'b0);
    check_val("mid_rst_waitrequest", cpu_waitrequest, 1'b1);
    check_val("mid_rst_readdata", cpu_readdata, 32'h0);
    check_val("mid_rst_addr", ram_addr, 8'h00);
    check_val("mid_rst_wdata", ram_wdata, 32'h0);
    check_val("mid_rst_be", ram_byteenable, 4'h0);
    check_val("mid_rst_mondreg", MonDReg, 32'h0);
    check_val("mid_rst_ready", monitor_ready, 1'b0);
    check_val("mid_rst_overflow", jtag_overflow, 1'b0);
    tick();
    acc_q.delete();
    e = mem[8'h00];
    jtag_pulse(1, mk_jdo(8'h00, 0, 0, 32'h0));
    jtag_wait(1, e, 4);
    check_acc("post_rst_ptr", 1, 0, 8'h00, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pru1_cpu_oci_ram_arbiter.md
Name: pru1_cpu_oci_ram_arbiter

Overview:
- Shares the single-port on-chip debug monitor RAM between two requesters.
  - JTAG host side: command pulses plus the 38-bit jdo payload from the sysclk half of the debug module.
  - CPU side: the Avalon-MM debug slave port.
- Decodes JTAG ocimem commands and keeps a post-incrementing JTAG address pointer.
- Round-robin arbitrates accesses, returns read data to MonDReg, and raises monitor_ready.
- Sits between the debug-module wrapper outputs and the OCI RAM macro, all in the clk domain.

Parameters:
- ADDR_W, 8, RAM word-address width; supported range 1..14 (address field is jdo[ADDR_W+16:17]).
- DATA_W, 32, RAM data width; fixed at 32, elaboration error otherwise.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- jdo  in  38  JTAG data payload, valid in the cycle a take_* pulse is high
- take_action_ocimem_a  in  1  load JTAG address pointer; if jdo[34]=1, also queue a read
- take_no_action_ocimem_a  in  1  queue a read at the pointer, then post-increment
- take_action_ocimem_b  in  1  queue a write of jdo[34:3] at the pointer, then post-increment
- cpu_address  in  ADDR_W  Avalon word address
- cpu_read  in  1  Avalon read request
- cpu_write  in  1  Avalon write request
- cpu_writedata  in  32  Avalon write data
- cpu_byteenable  in  4  Avalon byte enables
- cpu_waitrequest  out  1  Avalon stall
- cpu_readdata  out  32  Avalon read data, valid when read and !waitrequest
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_byteenable  out  4  RAM byte enables
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe; ram_rdata valid the next cycle
- ram_rdata  in  32  RAM read data
- MonDReg  out  32  last JTAG read result
- monitor_ready  out  1  JTAG read/write completed
- jtag_overflow  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset values:
  - FSM=ARB, pointer=0, JTAG pending=0, last_grant=CPU.
  - MonDReg=0, monitor_ready=0, jtag_overflow=0.
  - cpu_waitrequest=1, cpu_readdata=0.
  - ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, ram_byteenable=0.
- Reset mid-operation aborts any access with no RAM write completed after the reset cycle; jtag_overflow is cleared.
- JTAG command intake (1-entry holding register {rd/wr, addr, data}):
  - Only one take_* pulse is high per cycle.
  - If the holding register is empty: capture the command, clear monitor_ready, post-increment the pointer mod 2^ADDR_W at capture.
  - ocimem_a loads the pointer from jdo[ADDR_W+16:17]. With jdo[34]=0 nothing is queued and monitor_ready is untouched.
  - If the holding register is full: drop the command, set jtag_overflow (cleared only by reset), leave the pointer unchanged.
  - A pulse in the same cycle the pending entry is granted is accepted, because the register frees at grant.
- CPU requests: cpu_read and cpu_write are never both high; the master holds the request until waitrequest=0.
- FSM states: ARB, ISSUE, DONE.
  - ARB: if only one requester is pending, grant it. If both, grant the one != last_grant (the first tie after reset goes to JTAG). Latch addr/data/be/type, update last_grant, go to ISSUE. No request: stay in ARB.
  - ISSUE: drive ram_addr/ram_wdata/ram_byteenable with ram_we or ram_re for exactly 1 cycle.
    - Write: go to ARB. CPU write: cpu_waitrequest=0 this cycle. JTAG write: monitor_ready=1 from the next cycle.
    - Read: go to DONE.
  - DONE: CPU read: cpu_readdata=ram_rdata, cpu_waitrequest=0 this cycle. JTAG read: MonDReg<=ram_rdata, monitor_ready=1 from the next cycle. Go to ARB.
- JTAG writes use byteenable 4'hF.
- cpu_waitrequest is 1 in every cycle other than those listed above.
- Latency from request to waitrequest low: CPU write is 2 cycles when uncontended. CPU read is 3 cycles.
- Worst-case CPU wait is one JTAG access (≤3 cycles) plus its own access.

Decomposition:
- Shared package pru1_cpu_oci_pkg:
  - FSM state enum (ARB/ISSUE/DONE) and requester enum (GRANT_CPU/GRANT_JTAG).
  - jdo field constants: JDO_ADDR_LSB=17, JDO_RDEN_BIT=34, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3.
- One sub-module: pru1_cpu_oci_jtag_cmd, covering jdo decode, pointer, holding register and overflow flag. Arbiter FSM stays in the top.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[24:17]=8'h10, jdo[34]=1 -> ram_re with ram_addr=0x10 3 cycles later; with ram_rdata=0xDEADBEEF, MonDReg=0xDEADBEEF and monitor_ready=1 one cycle after DONE; pointer=0x11.
- Three ocimem_b writes (0x1,0x2,0x3) spaced 4 cycles apart, starting with pointer=0xFE -> ram_we at addresses 0xFE, 0xFF, 0x00 (wrap), byteenable 4'hF.
- CPU write addr 0x05 data 0xA5A5A5A5 be 4'b0011, held -> cpu_waitrequest low exactly in the 2nd cycle; ram_we=1 with be 4'b0011.
- CPU read and JTAG read pending in the same cycle after reset -> JTAG granted first (addr order JTAG then CPU); a repeated simultaneous tie next time -> CPU granted first.
- Two JTAG pulses on consecutive cycles while a CPU read holds the RAM -> first queued, second dropped; jtag_overflow=1, pointer advanced by exactly 1.
- Reset asserted in ISSUE of a CPU write -> no ram_we the following cycle; all outputs return to their reset values and cpu_waitrequest=1.
